// File: rtl/pipelined_ctrl_unit_pkg.sv
// Shared encodings for the decode/control stage: opcodes, operand-select and
// compare encodings, halt FSM states and the decoded control bundle.
package ctrl_pkg;

  localparam logic [3:0] OP_ALU  = 4'd15;
  localparam logic [3:0] OP_LD   = 4'd11;
  localparam logic [3:0] OP_ST   = 4'd8;
  localparam logic [3:0] OP_BGT  = 4'd4;
  localparam logic [3:0] OP_BLT  = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd0;

  localparam logic [1:0] CMP_GT = 2'd0;
  localparam logic [1:0] CMP_LT = 2'd1;
  localparam logic [1:0] CMP_EQ = 2'd2;

  localparam logic [1:0] SE_OP1 = 2'd0;
  localparam logic [1:0] SE_OP2 = 2'd1;
  localparam logic [1:0] SE_IMM = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_t;

  typedef struct packed {
    logic [3:0] dest;
    logic [3:0] alu_func;
    logic [7:0] offset;
    logic [1:0] sign_extend;
    logic [1:0] compare_type;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       halt;
  } ctrl_bundle_t;

endpackage

// File: rtl/pipelined_ctrl_unit_if.sv
// Bus between IF/ID + hazard/branch logic (master) and the control stage (slave).
interface pipelined_ctrl_unit_if #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic               hazard_detected;
  logic               branch_taken;

  logic               fetch_stall;
  logic               ctrl_valid;
  logic [3:0]         opcode;
  logic [3:0]         op1;
  logic [3:0]         op2;
  logic [3:0]         dest;
  logic [3:0]         alu_func;
  logic [7:0]         offset;
  logic [1:0]         sign_extend;
  logic [1:0]         compare_type;
  logic               reg_write;
  logic               mem_read;
  logic               mem_write;
  logic               branch;
  logic               jump;
  logic               halt;
  logic               flush;
  logic               halted;
  logic               illegal_instr;
  logic [CNT_W-1:0]   stall_count;
  logic [CNT_W-1:0]   flush_count;

  modport master (
    output instr_valid, instruction, hazard_detected, branch_taken,
    input  fetch_stall, ctrl_valid, opcode, op1, op2, dest, alu_func, offset,
           sign_extend, compare_type, reg_write, mem_read, mem_write, branch,
           jump, halt, flush, halted, illegal_instr, stall_count, flush_count
  );

  modport slave (
    input  instr_valid, instruction, hazard_detected, branch_taken,
    output fetch_stall, ctrl_valid, opcode, op1, op2, dest, alu_func, offset,
           sign_extend, compare_type, reg_write, mem_read, mem_write, branch,
           jump, halt, flush, halted, illegal_instr, stall_count, flush_count
  );
endinterface

// File: rtl/pipelined_ctrl_unit_decode_rom.sv
// Combinational opcode -> control bundle. Undefined opcodes decode as halt
// and raise the illegal flag so the core stops instead of running garbage.
module ctrl_decode_rom
  import ctrl_pkg::*;
(
  input  logic [3:0]   i_opcode,
  input  logic [3:0]   i_op1,
  input  logic [3:0]   i_op2,
  input  logic [3:0]   i_lo,
  output ctrl_bundle_t o_ctrl,
  output logic         o_illegal
);

  // Decode table lookup.
  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_ALU: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.dest      = i_op1;
        o_ctrl.alu_func  = i_lo;
      end
      OP_LD: begin
        o_ctrl.reg_write   = 1'b1;
        o_ctrl.mem_read    = 1'b1;
        o_ctrl.dest        = i_op1;
        o_ctrl.sign_extend = SE_IMM;
        o_ctrl.offset      = {4'h0, i_lo};
      end
      OP_ST: begin
        o_ctrl.mem_write   = 1'b1;
        o_ctrl.sign_extend = SE_IMM;
        o_ctrl.offset      = {4'h0, i_lo};
      end
      OP_BGT, OP_BLT, OP_BEQ: begin
        o_ctrl.branch      = 1'b1;
        o_ctrl.sign_extend = SE_OP2;
        o_ctrl.offset      = {i_op2, i_lo};
        o_ctrl.compare_type = (i_opcode == OP_BGT) ? CMP_GT :
                              (i_opcode == OP_BLT) ? CMP_LT : CMP_EQ;
      end
      OP_JMP: begin
        o_ctrl.jump        = 1'b1;
        o_ctrl.sign_extend = SE_OP1;
        o_ctrl.offset      = {i_op2, i_lo};
      end
      OP_HALT: o_ctrl.halt = 1'b1;
      default: begin
        o_ctrl.halt = 1'b1;
        o_illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipelined_ctrl_unit.sv
// Registered decode/control stage between IF/ID and EX. Handles hazard
// stalls, branch/jump flush bubbles and a RUN -> DRAIN -> HALTED halt FSM.
// Optional perf counters are built when CTRL_PERF_CNT_EN is defined;
// otherwise stall_count/flush_count read as 0.
module pipelined_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int INSTR_W      = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pipelined_ctrl_unit_if.slave  bus
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

  logic [3:0]   w_opcode, w_op1, w_op2, w_lo;
  ctrl_bundle_t w_dec;
  logic         w_illegal;

  halt_state_t     r_state, w_state_nxt;
  logic [FC_W-1:0] r_flush_cnt, w_flush_cnt_nxt;
  logic [DC_W-1:0] r_drain_cnt, w_drain_cnt_nxt;
  logic            w_issue, w_flush_bubble, w_hazard_stall, w_fetch_stall;

  ctrl_bundle_t r_ctrl;
  logic [3:0]   r_opcode, r_op1, r_op2;
  logic         r_valid, r_flush, r_illegal;

  assign w_opcode = bus.instruction[INSTR_W-1 -: 4];
  assign w_op1    = bus.instruction[INSTR_W-5 -: 4];
  assign w_op2    = bus.instruction[INSTR_W-9 -: 4];
  assign w_lo     = bus.instruction[INSTR_W-13 -: 4];

  ctrl_decode_rom u_rom (
    .i_opcode  (w_opcode),
    .i_op1     (w_op1),
    .i_op2     (w_op2),
    .i_lo      (w_lo),
    .o_ctrl    (w_dec),
    .o_illegal (w_illegal)
  );

  // Issue priority (flush > hazard > valid > bubble) and halt FSM next state.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_issue         = 1'b0;
    w_flush_bubble  = 1'b0;
    w_hazard_stall  = 1'b0;
    w_fetch_stall   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.branch_taken) begin
          w_flush_bubble  = 1'b1;
          w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
        end else if (r_flush_cnt != '0) begin
          w_flush_bubble  = 1'b1;
          w_flush_cnt_nxt = r_flush_cnt - 1'b1;
        end else if (bus.hazard_detected) begin
          w_hazard_stall = 1'b1;
          w_fetch_stall  = 1'b1;
        end else if (bus.instr_valid) begin
          w_issue = 1'b1;
          if (w_dec.jump) w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES);
          if (w_dec.halt) begin
            w_state_nxt     = ST_DRAIN;
            w_drain_cnt_nxt = DC_W'(DRAIN_CYCLES - 1);
          end
        end
      end
      ST_DRAIN: begin
        // A taken branch here means the halt was fetched down the wrong path.
        if (bus.branch_taken) begin
          w_state_nxt     = ST_RUN;
          w_flush_bubble  = 1'b1;
          w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
        end else begin
          w_fetch_stall = 1'b1;
          if (r_drain_cnt == '0) w_state_nxt = ST_HALTED;
          else                   w_drain_cnt_nxt = r_drain_cnt - 1'b1;
        end
      end
      ST_HALTED: w_fetch_stall = 1'b1;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // State, counters and the registered control bundle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_drain_cnt <= '0;
      r_ctrl      <= '0;
      r_opcode    <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_valid     <= 1'b0;
      r_flush     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_valid     <= w_issue;
      r_flush     <= w_flush_bubble;
      r_ctrl      <= w_issue ? w_dec    : '0;
      r_opcode    <= w_issue ? w_opcode : '0;
      r_op1       <= w_issue ? w_op1    : '0;
      r_op2       <= w_issue ? w_op2    : '0;
      if (w_issue && w_illegal) r_illegal <= 1'b1;
    end
  end

  assign bus.fetch_stall   = w_fetch_stall;
  assign bus.ctrl_valid    = r_valid;
  assign bus.opcode        = r_opcode;
  assign bus.op1           = r_op1;
  assign bus.op2           = r_op2;
  assign bus.dest          = r_ctrl.dest;
  assign bus.alu_func      = r_ctrl.alu_func;
  assign bus.offset        = r_ctrl.offset;
  assign bus.sign_extend   = r_ctrl.sign_extend;
  assign bus.compare_type  = r_ctrl.compare_type;
  assign bus.reg_write     = r_ctrl.reg_write;
  assign bus.mem_read      = r_ctrl.mem_read;
  assign bus.mem_write     = r_ctrl.mem_write;
  assign bus.branch        = r_ctrl.branch;
  assign bus.jump          = r_ctrl.jump;
  assign bus.halt          = r_ctrl.halt;
  assign bus.flush         = r_flush;
  assign bus.halted        = (r_state == ST_HALTED);
  assign bus.illegal_instr = r_illegal;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_count, r_flush_count;

  // Saturating perf counters for hazard stalls and flush bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_hazard_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
      if (w_flush_bubble && (r_flush_count != '1)) r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;
`else
  assign bus.stall_count = CNT_W'(0);
  assign bus.flush_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Directed bench for pipelined_ctrl_unit with FLUSH_CYCLES=2, DRAIN_CYCLES=3.
module tb_pipelined_ctrl_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipelined_ctrl_unit_if #(.INSTR_W(16), .CNT_W(16)) bus ();

  pipelined_ctrl_unit #(
    .INSTR_W(16), .FLUSH_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic haz, input logic br);
    bus.instr_valid     = v;
    bus.instruction     = ins;
    bus.hazard_detected = haz;
    bus.branch_taken    = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] perf(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_valid",   bus.ctrl_valid, 0);
    chk("rst_halted",  bus.halted, 0);
    chk("rst_stall",   bus.fetch_stall, 0);
    chk("rst_illegal", bus.illegal_instr, 0);
    chk("rst_flush",   bus.flush, 0);
    chk("rst_regwr",   bus.reg_write, 0);
    chk("rst_scnt",    bus.stall_count, 0);
    rst = 1'b0;

    // ALU decode
    drive(1'b1, 16'hF123, 1'b0, 1'b0);
    #1 chk("alu_fstall", bus.fetch_stall, 0);
    tick();
    chk("alu_valid", bus.ctrl_valid, 1);
    chk("alu_opc",   bus.opcode, 4'hF);
    chk("alu_op1",   bus.op1, 1);
    chk("alu_op2",   bus.op2, 2);
    chk("alu_func",  bus.alu_func, 3);
    chk("alu_dest",  bus.dest, 1);
    chk("alu_regwr", bus.reg_write, 1);
    chk("alu_mrd",   bus.mem_read, 0);

    // Load then store
    drive(1'b1, 16'hB456, 1'b0, 1'b0);
    tick();
    chk("ld_mrd",  bus.mem_read, 1);
    chk("ld_rw",   bus.reg_write, 1);
    chk("ld_off",  bus.offset, 8'h06);
    chk("ld_se",   bus.sign_extend, 2);
    chk("ld_dest", bus.dest, 4);
    drive(1'b1, 16'h8789, 1'b0, 1'b0);
    tick();
    chk("st_mwr",  bus.mem_write, 1);
    chk("st_dest", bus.dest, 0);
    chk("st_rw",   bus.reg_write, 0);
    chk("st_off",  bus.offset, 8'h09);
    chk("st_se",   bus.sign_extend, 2);

    // Hazard for 2 cycles
    drive(1'b1, 16'hF123, 1'b1, 1'b0);
    #1 chk("hz_fstall1", bus.fetch_stall, 1);
    tick();
    chk("hz_bub1", bus.ctrl_valid, 0);
    chk("hz_nofl1", bus.flush, 0);
    chk("hz_fstall2", bus.fetch_stall, 1);
    tick();
    chk("hz_bub2", bus.ctrl_valid, 0);
    drive(1'b1, 16'hF123, 1'b0, 1'b0);
    #1 chk("hz_release", bus.fetch_stall, 0);
    tick();
    chk("hz_issue", bus.ctrl_valid, 1);
    chk("hz_regwr", bus.reg_write, 1);
    chk("hz_scnt",  bus.stall_count, perf(2));

    // BEQ then taken branch: 2 flush bubbles
    drive(1'b1, 16'h6A10, 1'b0, 1'b0);
    tick();
    chk("beq_br",  bus.branch, 1);
    chk("beq_cmp", bus.compare_type, 2);
    chk("beq_se",  bus.sign_extend, 1);
    chk("beq_off", bus.offset, 8'h10);
    drive(1'b1, 16'hF123, 1'b0, 1'b1);
    #1 chk("br_fstall", bus.fetch_stall, 0);
    tick();
    chk("br_fl1",  bus.flush, 1);
    chk("br_v1",   bus.ctrl_valid, 0);
    chk("br_rw1",  bus.reg_write, 0);
    drive(1'b1, 16'hF123, 1'b0, 1'b0);
    tick();
    chk("br_fl2",  bus.flush, 1);
    chk("br_v2",   bus.ctrl_valid, 0);
    tick();
    chk("br_fl3",  bus.flush, 0);
    chk("br_v3",   bus.ctrl_valid, 1);
    chk("br_fcnt", bus.flush_count, perf(2));

    // Jump: FLUSH_CYCLES bubbles follow automatically
    drive(1'b1, 16'hC0AB, 1'b0, 1'b0);
    tick();
    chk("jmp_j",   bus.jump, 1);
    chk("jmp_off", bus.offset, 8'hAB);
    chk("jmp_se",  bus.sign_extend, 0);
    drive(1'b1, 16'hF123, 1'b0, 1'b0);
    tick();
    chk("jmp_fl1", bus.flush, 1);
    tick();
    chk("jmp_fl2", bus.flush, 1);
    tick();
    chk("jmp_v",   bus.ctrl_valid, 1);
    chk("jmp_fl3", bus.flush, 0);

    // Simultaneous branch and hazard: flush wins, and flush_cnt still wins
    drive(1'b1, 16'hF123, 1'b1, 1'b1);
    #1 chk("bh_fstall", bus.fetch_stall, 0);
    tick();
    chk("bh_fl1", bus.flush, 1);
    drive(1'b1, 16'hF123, 1'b1, 1'b0);
    #1 chk("bh_fstall2", bus.fetch_stall, 0);
    tick();
    chk("bh_fl2", bus.flush, 1);
    drive(1'b1, 16'hF123, 1'b0, 1'b0);
    tick();
    chk("bh_v",    bus.ctrl_valid, 1);
    chk("bh_scnt", bus.stall_count, perf(2));
    chk("bh_fcnt", bus.flush_count, perf(6));

    // Halt drain
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
    tick();
    chk("hlt_halt",  bus.halt, 1);
    chk("hlt_valid", bus.ctrl_valid, 1);
    chk("hlt_ill",   bus.illegal_instr, 0);
    drive(1'b1, 16'hF123, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drn_fstall%0d", i), bus.fetch_stall, 1);
      chk($sformatf("drn_halted%0d", i), bus.halted, 0);
      tick();
      chk($sformatf("drn_bub%0d", i), bus.ctrl_valid, 0);
    end
    chk("hlt_halted", bus.halted, 1);
    chk("hlt_fstall", bus.fetch_stall, 1);
    drive(1'b1, 16'hF123, 1'b0, 1'b1);
    tick(); tick();
    chk("hlt_hold",  bus.halted, 1);
    chk("hlt_nofl",  bus.flush, 0);
    chk("hlt_bub",   bus.ctrl_valid, 0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("hlt_rst", bus.halted, 0);

    // Halt on wrong path: branch taken in 2nd DRAIN cycle
    drive(1'b1, 16'h0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'hF123, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'hF123, 1'b0, 1'b1);
    #1 chk("wp_fstall", bus.fetch_stall, 0);
    tick();
    chk("wp_fl1",    bus.flush, 1);
    chk("wp_halted", bus.halted, 0);
    drive(1'b1, 16'hF123, 1'b0, 1'b0);
    tick();
    chk("wp_fl2", bus.flush, 1);
    tick();
    chk("wp_valid",   bus.ctrl_valid, 1);
    chk("wp_halted2", bus.halted, 0);
    chk("wp_fstall2", bus.fetch_stall, 0);

    // Illegal opcode, then reset mid-DRAIN
    drive(1'b1, 16'h3000, 1'b0, 1'b0);
    tick();
    chk("ill_halt", bus.halt, 1);
    chk("ill_flag", bus.illegal_instr, 1);
    chk("ill_opc",  bus.opcode, 3);
    drive(1'b1, 16'hF123, 1'b0, 1'b0);
    tick();
    chk("ill_sticky", bus.illegal_instr, 1);
    chk("ill_drain",  bus.fetch_stall, 1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1; tick();
    chk("mrst_valid",  bus.ctrl_valid, 0);
    chk("mrst_halt",   bus.halt, 0);
    chk("mrst_ill",    bus.illegal_instr, 0);
    chk("mrst_halted", bus.halted, 0);
    chk("mrst_fstall", bus.fetch_stall, 0);
    chk("mrst_scnt",   bus.stall_count, 0);
    chk("mrst_fcnt",   bus.flush_count, 0);
    rst = 1'b0;
    drive(1'b1, 16'hF123, 1'b0, 1'b0);
    tick();
    chk("mrst_run", bus.ctrl_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
